// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the data stage.
// One transaction in flight; data port has priority, fetch is protected from starvation.
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              flush_i,
  input  logic              if_req_i,
  input  logic [XLEN-1:0]   if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [XLEN-1:0]   if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [XLEN/8-1:0] dm_be_i,
  input  logic [XLEN-1:0]   dm_addr_i,
  input  logic [XLEN-1:0]   dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [XLEN-1:0]   dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              busy_o,
  output logic [1:0]        dbg_state_o
);

  localparam int BEW = XLEN / 8;
  localparam int SW  = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            owner_if_q, owner_if_d;
  logic            squash_q, squash_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [BEW-1:0]  mem_be_q, mem_be_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic            if_rvalid_q, if_rvalid_d;
  logic [XLEN-1:0] if_rdata_q, if_rdata_d;
  logic            dm_rvalid_q, dm_rvalid_d;
  logic [XLEN-1:0] dm_rdata_q, dm_rdata_d;

  logic if_eff, contend, if_wins, grant_if, grant_dm;

  // Handshakes: a requester holds *_req_i until it sees *_gnt_o high in the same
  // cycle; mem_req_o is held until mem_gnt_i; *_rvalid_o are single-cycle pulses.
  always_comb begin
    if_eff   = if_req_i & ~flush_i;
    contend  = if_eff & dm_req_i;
    if_wins  = (starve_q == SW'(STARVE_MAX));
    grant_if = rstn_i && (state_q == ST_IDLE) && if_eff && (!dm_req_i || if_wins);
    grant_dm = rstn_i && (state_q == ST_IDLE) && dm_req_i && !(if_eff && if_wins);
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    owner_if_d  = owner_if_q;
    squash_d    = squash_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rvalid_d = 1'b0;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_if || grant_dm) begin
          state_d    = ST_ISSUE;
          mem_req_d  = 1'b1;
          owner_if_d = grant_if;
          if (grant_if) begin
            mem_we_d    = 1'b0;
            mem_be_d    = '1;
            mem_addr_d  = if_addr_i;
            mem_wdata_d = '0;
            starve_d    = '0;
          end else begin
            mem_we_d    = dm_we_i;
            mem_be_d    = dm_we_i ? dm_be_i : '1;
            mem_addr_d  = dm_addr_i;
            mem_wdata_d = dm_wdata_i;
            // Fetch lost a contended cycle; DM only wins while below the limit.
            if (contend) starve_d = starve_q + SW'(1);
          end
        end
      end
      ST_ISSUE: begin
        if (flush_i && owner_if_q) squash_d = 1'b1;
        if (mem_gnt_i) begin
          mem_req_d = 1'b0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush_i && owner_if_q) squash_d = 1'b1;
        if (mem_rvalid_i) begin
          state_d  = ST_IDLE;
          squash_d = 1'b0;
          if (owner_if_q) begin
            // A flush landing on the completion cycle squashes too.
            if (!(squash_q || flush_i)) begin
              if_rvalid_d = 1'b1;
              if_rdata_d  = mem_rdata_i;
            end
          end else begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = mem_we_q ? '0 : mem_rdata_i;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      owner_if_q  <= 1'b0;
      squash_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rvalid_q <= 1'b0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      owner_if_q  <= owner_if_d;
      squash_q    <= squash_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rvalid_q <= dm_rvalid_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign if_gnt_o    = grant_if;
  assign dm_gnt_o    = grant_dm;
  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rvalid_o = dm_rvalid_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: random requesters and memory, transaction-level
// reference model feeding expected queues, negedge monitor comparing DUT outputs.
module tb_mem_port_arbiter;
  localparam int XLEN       = 32;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn_i = 1'b0, flush_i = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i = 1'b0, dm_we_i = 1'b0;
  logic [3:0]  dm_be_i = '0;
  logic [31:0] dm_addr_i = '0, dm_wdata_i = '0;
  logic        dm_gnt_o, dm_rvalid_o;
  logic [31:0] dm_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        busy_o;
  logic [1:0]  dbg_state_o;

  mem_port_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .flush_i(flush_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
    .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
    .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .dbg_state_o(dbg_state_o)
  );

  int checks = 0, errors = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // Reference model: transaction phase 0=idle 1=issue 2=wait
  int   m_phase = 0, m_starve = 0, gcnt = 0, rcnt = 0, cyc = 0;
  bit   m_owner_if = 0, m_we = 0, m_squash = 0;
  bit   if_pend = 0, dm_pend = 0, dm_we_v = 0;
  logic [31:0] if_addr_v = '0, dm_addr_v = '0, dm_wdata_v = '0;
  logic [3:0]  dm_be_v = '0;

  int p_if = 0, p_dm = 0, p_flush = 0, gnt_min = 0, gnt_max = 0, rv_min = 0, rv_max = 0;
  bit spur_en = 0, rv_hold = 0, late_rv = 0, rst_req = 0, flush_wait_once = 0, force_rd_en = 0;
  logic [31:0] force_rd = '0;

  bit exp_if_gnt = 0, exp_dm_gnt = 0, exp_busy = 0, exp_mem_req = 0, exp_resp_now = 0, exp_zero = 0;
  logic [68:0] mem_exp_q[$];
  logic [32:0] exp_q[$];

  bit mon_en = 1, log_en = 0, mem_req_prev = 0;
  int gnt_log[$];
  int if_rv_cnt = 0, dm_rv_cnt = 0, bp_bad = 0, g_cyc = 0, rv_cyc = 0;
  logic [31:0] last_dm_rdata = '0;
  logic [68:0] cur_mem = '0;

  // 0 = none, 1 = DM, 2 = IF, from the arbitration rules on the current inputs
  function automatic int winner();
    bit if_ok;
    if (!rstn_i || m_phase != 0) return 0;
    if_ok = if_req_i && !flush_i;
    if (dm_req_i && if_ok) return (m_starve == STARVE_MAX) ? 2 : 1;
    if (dm_req_i) return 1;
    if (if_ok) return 2;
    return 0;
  endfunction

  function automatic void model_update();
    int w;
    exp_resp_now = 0;
    exp_zero = 0;
    if (!rstn_i) begin
      m_phase = 0; m_starve = 0; m_squash = 0; exp_zero = 1;
    end else begin
      case (m_phase)
        0: begin
          w = winner();
          if (w == 1) begin
            if (if_req_i && !flush_i && m_starve < STARVE_MAX) m_starve++;
            m_owner_if = 0; m_we = dm_we_i; dm_pend = 0;
            mem_exp_q.push_back({dm_we_i, (dm_we_i ? dm_be_i : 4'hf), dm_addr_i, dm_wdata_i});
          end else if (w == 2) begin
            m_starve = 0; m_owner_if = 1; m_we = 0; if_pend = 0;
            mem_exp_q.push_back({1'b0, 4'hf, if_addr_i, 32'h0});
          end
          if (w != 0) begin
            m_phase = 1;
            gcnt = $urandom_range(gnt_max, gnt_min);
          end
        end
        1: begin
          if (flush_i && m_owner_if) m_squash = 1;
          if (mem_gnt_i) begin
            m_phase = 2;
            rcnt = $urandom_range(rv_max, rv_min);
          end
        end
        default: begin
          if (flush_i && m_owner_if) m_squash = 1;
          if (mem_rvalid_i) begin
            if (!(m_owner_if && m_squash)) begin
              exp_q.push_back({m_owner_if, (m_we ? 32'h0 : mem_rdata_i)});
              exp_resp_now = 1;
            end
            m_phase = 0;
            m_squash = 0;
          end
        end
      endcase
    end
  endfunction

  function automatic void choose_inputs();
    int w;
    rstn_i = !rst_req;
    rst_req = 0;
    if (!if_pend && int'($urandom_range(15, 0)) < p_if) begin
      if_pend = 1; if_addr_v = $urandom & ~32'h3;
    end
    if (!dm_pend && int'($urandom_range(15, 0)) < p_dm) begin
      dm_pend = 1; dm_we_v = 1'($urandom_range(1, 0)); dm_be_v = 4'($urandom);
      dm_addr_v = $urandom; dm_wdata_v = $urandom;
    end
    if_req_i = if_pend; if_addr_i = if_addr_v;
    dm_req_i = dm_pend; dm_we_i = dm_we_v; dm_be_i = dm_be_v;
    dm_addr_i = dm_addr_v; dm_wdata_i = dm_wdata_v;
    flush_i = (int'($urandom_range(15, 0)) < p_flush);
    if (flush_wait_once && m_phase == 2) begin
      flush_i = 1; flush_wait_once = 0;
    end
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = $urandom;
    case (m_phase)
      0: if (spur_en) begin
        mem_gnt_i = ($urandom_range(3, 0) == 0);
        mem_rvalid_i = ($urandom_range(3, 0) == 0);
      end
      1: begin
        if (gcnt == 0) mem_gnt_i = 1; else gcnt--;
        if (spur_en) mem_rvalid_i = ($urandom_range(3, 0) == 0);
      end
      default: begin
        if (!rv_hold) begin
          if (rcnt == 0) begin
            mem_rvalid_i = 1;
            if (force_rd_en) mem_rdata_i = force_rd;
          end else rcnt--;
        end
        if (spur_en) mem_gnt_i = ($urandom_range(3, 0) == 0);
      end
    endcase
    if (late_rv) begin
      mem_rvalid_i = 1; late_rv = 0;
    end
    w = winner();
    exp_if_gnt = (w == 2);
    exp_dm_gnt = (w == 1);
    exp_busy = (m_phase != 0);
    exp_mem_req = (m_phase == 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    model_update();
    choose_inputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("if_gnt", if_gnt_o, exp_if_gnt);
      chk("dm_gnt", dm_gnt_o, exp_dm_gnt);
      chk("busy", busy_o, exp_busy);
      chk("mem_req", mem_req_o, exp_mem_req);
      chk("rvalid_timing", if_rvalid_o | dm_rvalid_o, exp_resp_now);
      if ((if_gnt_o || dm_gnt_o) && busy_o) bp_bad++;
      if (log_en) begin
        if (dm_gnt_o) gnt_log.push_back(1);
        if (if_gnt_o) gnt_log.push_back(2);
      end
      if (dm_gnt_o) g_cyc = cyc;
      if (mem_req_o) begin
        if (!mem_req_prev) begin
          if (mem_exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL mem_req_unexpected actual=%0h expected=none", mem_addr_o);
          end else cur_mem = mem_exp_q.pop_front();
        end
        chk("mem_we", mem_we_o, cur_mem[68]);
        chk("mem_be", mem_be_o, cur_mem[67:64]);
        chk("mem_addr", mem_addr_o, cur_mem[63:32]);
        if (cur_mem[68]) chk("mem_wdata", mem_wdata_o, cur_mem[31:0]);
      end
      if (if_rvalid_o || dm_rvalid_o) begin
        chk("rvalid_onehot", if_rvalid_o & dm_rvalid_o, 0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp_unexpected actual=%0h expected=none", {if_rvalid_o, dm_rvalid_o});
        end else begin
          logic [32:0] r;
          r = exp_q.pop_front();
          chk("resp_port", if_rvalid_o, r[32]);
          chk("resp_data", if_rvalid_o ? if_rdata_o : dm_rdata_o, r[31:0]);
        end
        if (if_rvalid_o) if_rv_cnt++;
        if (dm_rvalid_o) begin
          dm_rv_cnt++; last_dm_rdata = dm_rdata_o; rv_cyc = cyc;
        end
      end
      if (exp_zero)
        chk("reset_zero", {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
                           if_rvalid_o, dm_rvalid_o, if_rdata_o, dm_rdata_o}, 0);
      mem_req_prev = mem_req_o;
    end
  end

  initial begin
    int exp_pat[10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
    int base;
    run(3);

    // Single load from 0x100
    force_rd_en = 1; force_rd = 32'hDEADBEEF;
    dm_pend = 1; dm_we_v = 0; dm_addr_v = 32'h100; dm_be_v = 4'h0; dm_wdata_v = '0;
    run(6);
    force_rd_en = 0;
    chk("load_count", dm_rv_cnt, 1);
    chk("load_data", last_dm_rdata, 32'hDEADBEEF);
    chk("load_latency", rv_cyc - g_cyc, 3);
    chk("load_if_quiet", if_rv_cnt, 0);

    // Store with partial byte enables
    dm_pend = 1; dm_we_v = 1; dm_addr_v = 32'h204; dm_be_v = 4'b0011; dm_wdata_v = 32'h1234;
    run(6);
    chk("store_count", dm_rv_cnt, 2);
    chk("store_rdata", last_dm_rdata, 0);
    chk("store_be", cur_mem[67:64], 4'b0011);

    // Continuous contention
    gnt_log.delete();
    log_en = 1; p_if = 16; p_dm = 16; if_pend = 1; dm_pend = 1;
    run(34);
    log_en = 0; p_if = 0; p_dm = 0;
    run(10);
    chk("contention_len_ok", gnt_log.size() >= 10, 1);
    if (gnt_log.size() >= 10)
      for (int i = 0; i < 10; i++) chk("contention_order", gnt_log[i], exp_pat[i]);

    // Memory backpressure: five idle cycles in ISSUE with requests queued
    gnt_min = 5; gnt_max = 5; p_if = 16; dm_pend = 1;
    dm_we_v = 1; dm_addr_v = 32'h300; dm_be_v = 4'hf; dm_wdata_v = 32'hCAFE0001;
    run(18);
    p_if = 0; gnt_min = 0; gnt_max = 0;
    run(12);

    // Flush squash on a fetch, then a normal fetch
    base = if_rv_cnt;
    rv_min = 2; rv_max = 2; flush_wait_once = 1;
    if_pend = 1; if_addr_v = 32'h40;
    run(10);
    chk("squash_no_if_rvalid", if_rv_cnt, base);
    rv_min = 0; rv_max = 0;
    if_pend = 1; if_addr_v = 32'h80;
    run(8);
    chk("post_squash_fetch", if_rv_cnt, base + 1);

    // Reset while waiting for the memory response, then a late rvalid
    base = dm_rv_cnt;
    rv_hold = 1;
    dm_pend = 1; dm_we_v = 0; dm_addr_v = 32'h500;
    for (int i = 0; i < 10 && m_phase != 2; i++) step();
    chk("rst_reached_wait", dbg_state_o, 2);
    rst_req = 1; if_pend = 1; if_addr_v = 32'h600;
    step();
    late_rv = 1;
    step();
    rv_hold = 0;
    chk("rst_busy_clear", busy_o, 0);
    run(8);
    chk("late_rvalid_dropped", dm_rv_cnt, base);

    // Randomized traffic
    spur_en = 1; p_if = 6; p_dm = 6; p_flush = 2;
    gnt_min = 0; gnt_max = 3; rv_min = 0; rv_max = 3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(399, 0) == 0) rst_req = 1;
      step();
    end
    spur_en = 0; p_if = 0; p_dm = 0; p_flush = 0;
    run(40);
    mon_en = 0;
    chk("mem_queue_drained", mem_exp_q.size(), 0);
    chk("resp_queue_drained", exp_q.size(), 0);
    chk("no_grant_while_busy", bp_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
